match_result_select_pipe: RTL and testbench



---
 rtl/match_sel_pkg.sv | 27 ++
 rtl/match_lane_sel.sv | 80 ++++++++
 rtl/match_result_select_pipe.sv | 105 ++++++++++
 tb/tb_match_result_select_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/match_sel_pkg.sv
// Purpose : shared defaults and elaboration-time helpers for the match-result select pipe.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: default lane geometry, a constant clog2, and a flat-bus slice index helper.
package match_sel_pkg;

  localparam int LANE_W_DEF    = 32;
  localparam int NUM_LANES_DEF = 4;

  // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bit offset of lane `lane` of word `word` inside a flat candidate bus.
  function automatic int lane_idx(input int word, input int lane,
                                  input int word_w, input int lane_w);
    return word * word_w + lane * lane_w;
  endfunction

endpackage

// File: rtl/match_lane_sel.sv
// Purpose : one output lane; GROUP:1 first-stage muxes, registered, then NUM_IN/GROUP:1 mux + mask.
// Latency : 2 cycles from s1_load_i to dat_o (one register per stage).
// Backpr. : none internally; registers hold whenever their load strobe is low.
//
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset (clears all data registers)
//   cand_i         - this lane of every candidate word, candidate i at [i*LANE_W +: LANE_W]
//   sel_i, en_i    - this lane's select and pass-enable
//   s1_load_i      - load stage-1 partials, high select and enable
//   s2_load_i      - load the output register from stage 1
//   dat_o          - registered lane result
module match_lane_sel
  import match_sel_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int LANE_W = LANE_W_DEF,
  parameter int GROUP  = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_IN*LANE_W-1:0] cand_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic                     en_i,
  input  logic                     s1_load_i,
  input  logic                     s2_load_i,
  output logic [LANE_W-1:0]        dat_o
);

  localparam int NUM_GRP = NUM_IN / GROUP;
  localparam int LO_W    = clog2(GROUP);
  localparam logic [SEL_W-1:0] LO_MASK = SEL_W'(GROUP - 1);

  logic [LANE_W-1:0] part_d [NUM_GRP];
  logic [LANE_W-1:0] part_q [NUM_GRP];
  logic [SEL_W-1:0]  hi_q;
  logic              en_q;
  logic [LANE_W-1:0] dat_d;
  logic [LANE_W-1:0] dat_q;

  // Stage 1: every group resolves its own member using only the low select bits.
  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      part_d[g] = '0;
      for (int j = 0; j < GROUP; j++) begin
        if ((sel_i & LO_MASK) == SEL_W'(j))
          part_d[g] = cand_i[(g*GROUP + j)*LANE_W +: LANE_W];
      end
    end
  end

  // Stage 2: registered high bits pick the group, the registered enable masks the lane.
  always_comb begin
    dat_d = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (hi_q == SEL_W'(g)) dat_d = part_q[g];
    end
    if (!en_q) dat_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int g = 0; g < NUM_GRP; g++) part_q[g] <= '0;
      hi_q <= '0;
      en_q <= 1'b0;
    end else if (s1_load_i) begin
      for (int g = 0; g < NUM_GRP; g++) part_q[g] <= part_d[g];
      hi_q <= sel_i >> LO_W;
      en_q <= en_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        dat_q <= '0;
    else if (s2_load_i) dat_q <= dat_d;
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/match_result_select_pipe.sv
// Purpose : per-lane NUM_IN:1 match-result select with lane masking, split over two register stages.
// Latency : 2 cycles accept-to-output; 1 word/cycle sustained.
// Backpr. : valid/ready; holds 2 words under full stall, in_ready_o follows out_ready_i combinationally.
//
// Ports:
//   clk_i, rst_ni            - kernel clock, async active-low reset
//   din_i                    - flat candidates, word i at [i*WORD_W +: WORD_W]
//   sel_i, lane_en_i         - per-lane select (SEL_W bits each) and lane pass-enable
//   in_valid_i / in_ready_o  - input handshake
//   flush_i                  - synchronous clear of both stages
//   dout_o, out_valid_o / out_ready_i - output word and handshake
//   xfer_cnt_o               - wrapping count of delivered words
module match_result_select_pipe
  import match_sel_pkg::*;
#(
  parameter int NUM_IN    = 16,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int LANE_W    = LANE_W_DEF,
  parameter int GROUP     = 4,
  localparam int SEL_W    = clog2(NUM_IN),
  localparam int WORD_W   = NUM_LANES * LANE_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_IN*WORD_W-1:0]   din_i,
  input  logic [NUM_LANES*SEL_W-1:0] sel_i,
  input  logic [NUM_LANES-1:0]       lane_en_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [WORD_W-1:0]          dout_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                xfer_cnt_o
);

  logic        s1_vld_q, s1_vld_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic        s2_adv;
  logic        s1_load;
  logic        deliver;

  // in_ready depends on out_ready and state only, never on in_valid.
  assign s2_adv     = s1_vld_q && (!out_vld_q || out_ready_i);
  assign in_ready_o = !flush_i && (!s1_vld_q || s2_adv);
  assign s1_load    = in_valid_i && in_ready_o;
  assign deliver    = out_vld_q && out_ready_i;

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (s1_load)     s1_vld_d = 1'b1;
    else if (s2_adv) s1_vld_d = 1'b0;
    if (flush_i)     s1_vld_d = 1'b0;

    out_vld_d = out_vld_q;
    if (s2_adv)           out_vld_d = 1'b1;
    else if (out_ready_i) out_vld_d = 1'b0;
    if (flush_i)          out_vld_d = 1'b0;

    // A delivery presented in a flush cycle still completes and is counted.
    xfer_cnt_d = xfer_cnt_q + {31'b0, deliver};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      out_vld_q  <= out_vld_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [NUM_IN*LANE_W-1:0] cand;

    // Gather lane k of every candidate word into a contiguous per-lane bus.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_cand
      assign cand[i*LANE_W +: LANE_W] = din_i[lane_idx(i, k, WORD_W, LANE_W) +: LANE_W];
    end

    match_lane_sel #(
      .NUM_IN (NUM_IN),
      .LANE_W (LANE_W),
      .GROUP  (GROUP),
      .SEL_W  (SEL_W)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cand_i    (cand),
      .sel_i     (sel_i[k*SEL_W +: SEL_W]),
      .en_i      (lane_en_i[k]),
      .s1_load_i (s1_load),
      .s2_load_i (s2_adv && !flush_i),
      .dat_o     (dout_o[k*LANE_W +: LANE_W])
    );
  end

  assign out_valid_o = out_vld_q;
  assign xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: tb/tb_match_result_select_pipe.sv
module tb_match_result_select_pipe;

  localparam int NUM_IN    = 16;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 32;
  localparam int GROUP     = 4;
  localparam int SEL_W     = 4;
  localparam int WORD_W    = 128;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_IN*WORD_W-1:0]   din;
  logic [NUM_LANES*SEL_W-1:0] sel;
  logic [NUM_LANES-1:0]       lane_en;
  logic                       in_valid;
  logic                       in_ready;
  logic                       flush;
  logic [WORD_W-1:0]          dout;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                xfer_cnt;

  always #5 clk = ~clk;

  match_result_select_pipe #(
    .NUM_IN    (NUM_IN),
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W),
    .GROUP     (GROUP)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_i       (din),
    .sel_i       (sel),
    .lane_en_i   (lane_en),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .dout_o      (dout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .xfer_cnt_o  (xfer_cnt)
  );

  typedef struct {
    logic [15:0]  sel;
    logic [3:0]   en;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [6];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] sb [$];
  bit           sb_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: lane k = {word index, lane index, A5A5} of the selected word, masked by enable.
  function automatic logic [127:0] model(input logic [15:0] s, input logic [3:0] e);
    logic [127:0] r;
    logic [3:0]   idx;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      idx = s[k*4 +: 4];
      if (e[k]) r[k*32 +: 32] = {4'h0, idx, 8'(k), 16'hA5A5};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for streaming/backpressure: compare on delivery, enqueue on accept.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_word", dout, 128'hX);
        else begin
          chk("sb_dout", dout, sb[0]);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(model(sel, lane_en));
    end
  end

  initial begin
    logic [31:0]  cnt0;
    logic [127:0] hold;
    int           acc;

    vecs[0] = '{16'h9999, 4'hF,    128'h0903A5A5_0902A5A5_0901A5A5_0900A5A5};
    vecs[1] = '{16'hF074, 4'b1011, 128'h0F03A5A5_00000000_0701A5A5_0400A5A5};
    vecs[2] = '{16'h0000, 4'hF,    128'h0003A5A5_0002A5A5_0001A5A5_0000A5A5};
    vecs[3] = '{16'hFFFF, 4'h0,    128'h0};
    vecs[4] = '{16'h3C5A, 4'b0110, 128'h00000000_0C02A5A5_0501A5A5_00000000};
    vecs[5] = '{16'h34BC, 4'hF,    128'h0303A5A5_0402A5A5_0B01A5A5_0C00A5A5};

    for (int i = 0; i < NUM_IN; i++)
      for (int k = 0; k < NUM_LANES; k++)
        din[i*WORD_W + k*LANE_W +: LANE_W] = {8'(i), 8'(k), 16'hA5A5};

    rst_n = 1'b0; sel = '0; lane_en = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_dout", dout, 128'd0);
    chk("rst_xfer_cnt", 128'(xfer_cnt), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    #10 rst_n = 1'b1;
    tick();

    // Table: single words, checking the 2-cycle latency and the selected/masked value.
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel; lane_en = vecs[v].en; in_valid = 1'b1;
      #1 chk("tbl_in_ready", 128'(in_ready), 128'd1);
      tick();
      in_valid = 1'b0;
      chk("tbl_lat_not_yet", 128'(out_valid), 128'd0);
      tick();
      chk("tbl_out_valid", 128'(out_valid), 128'd1);
      chk("tbl_dout", dout, vecs[v].exp);
      tick();
      chk("tbl_drained", 128'(out_valid), 128'd0);
    end
    chk("tbl_xfer_cnt", 128'(xfer_cnt), 128'd6);

    // Streaming: 100 back-to-back words.
    sb_en = 1'b1;
    cnt0 = xfer_cnt;
    for (int n = 0; n < 100; n++) begin
      sel = 16'($urandom); lane_en = 4'($urandom); in_valid = 1'b1;
      #1 chk("stream_in_ready", 128'(in_ready), 128'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stream_sb_empty", 128'(sb.size()), 128'd0);
    chk("stream_xfer", 128'(xfer_cnt - cnt0), 128'd100);

    // Backpressure: 5 stalled cycles with input offered.
    cnt0 = xfer_cnt;
    out_ready = 1'b0; in_valid = 1'b1; sel = 16'h1234; lane_en = 4'hF;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (in_ready) begin
        acc++;
        tick();
        sel = sel + 16'h1111;
      end else tick();
    end
    chk("bp_accepts", 128'(acc), 128'd2);
    chk("bp_in_ready_low", 128'(in_ready), 128'd0);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    hold = dout;
    tick();
    chk("bp_dout_stable", dout, hold);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("bp_in_ready_rise", 128'(in_ready), 128'd1);
    repeat (4) tick();
    chk("bp_sb_empty", 128'(sb.size()), 128'd0);
    chk("bp_xfer", 128'(xfer_cnt - cnt0), 128'd2);
    sb_en = 1'b0;

    // Flush with both stages full; the delivery in the flush cycle still counts.
    out_ready = 1'b0; in_valid = 1'b1; sel = 16'h1234; lane_en = 4'hF;
    tick();
    sel = 16'h9999;
    tick();
    in_valid = 1'b0;
    #1 chk("fl_full_in_ready", 128'(in_ready), 128'd0);
    cnt0 = xfer_cnt;
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    #1 chk("fl_in_ready_forced", 128'(in_ready), 128'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 128'(out_valid), 128'd0);
    chk("fl_s1_valid", 128'(dut.s1_vld_q), 128'd0);
    chk("fl_xfer", 128'(xfer_cnt - cnt0), 128'd1);
    sel = vecs[1].sel; lane_en = vecs[1].en; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fl_post_lat", 128'(out_valid), 128'd0);
    tick();
    chk("fl_post_valid", 128'(out_valid), 128'd1);
    chk("fl_post_dout", dout, vecs[1].exp);
    tick();

    // Reset mid-stream with a word held on the output.
    sel = vecs[0].sel; lane_en = vecs[0].en; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("mr_pre_valid", 128'(out_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_dout", dout, 128'd0);
    chk("mr_out_valid", 128'(out_valid), 128'd0);
    chk("mr_xfer", 128'(xfer_cnt), 128'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("mr_after_valid", 128'(out_valid), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
